// File: rtl/and_gate_project.sv
// Two raw board switches, synchronized and optionally debounced, ANDed onto a registered LED.
// Define AND_GATE_PROJECT_DEBOUNCE_EN to build in the per-switch debounce filter.
module and_gate_project #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  output logic o_LED_1
);

  logic [1:0]             sw_raw;
  logic [1:0]             sw_sync;
  logic [1:0]             sw_filt;
  logic [SYNC_STAGES-1:0] sync_q [2];

  assign sw_raw = {i_Switch_2, i_Switch_1};

  always_ff @(posedge i_Clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!i_Rst_n) begin
        sync_q[i] <= '0;
      end else begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sw_raw[i]};
      end
    end
  end

  always_comb begin
    sw_sync = '0;
    for (int i = 0; i < 2; i++) begin
      sw_sync[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

`ifdef AND_GATE_PROJECT_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [1:0]       sw_db;
  logic [CNT_W-1:0] cnt_q [2];

  // Any sample matching the debounced state restarts the run; the state flips
  // on the DEBOUNCE_LIMIT-th consecutive differing sample.
  always_ff @(posedge i_Clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!i_Rst_n) begin
        sw_db[i] <= 1'b0;
        cnt_q[i] <= '0;
      end else if (sw_sync[i] == sw_db[i]) begin
        cnt_q[i] <= '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        sw_db[i] <= sw_sync[i];
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign sw_filt = sw_db;
`else
  logic unused_debounce_limit;

  assign unused_debounce_limit = (DEBOUNCE_LIMIT < 1);
  assign sw_filt               = sw_sync;
`endif

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      o_LED_1 <= 1'b0;
    end else begin
      o_LED_1 <= &sw_filt;
    end
  end

endmodule

// File: tb/tb_and_gate_project.sv
// Directed, table-driven bench for and_gate_project with SYNC_STAGES=2, DEBOUNCE_LIMIT=4.
// Expectations follow AND_GATE_PROJECT_DEBOUNCE_EN, whichever way it is set for the build.
module tb_and_gate_project;

`ifdef AND_GATE_PROJECT_DEBOUNCE_EN
  localparam int LAT     = 7;
  localparam int PRE_RST = 4;
`else
  localparam int LAT     = 3;
  localparam int PRE_RST = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic sw_1;
  logic sw_2;
  logic led;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic s1;
    logic s2;
    int   hold;
    logic exp;
  } vec_t;

  vec_t vecs [6];

  and_gate_project #(
    .DEBOUNCE_LIMIT(4),
    .SYNC_STAGES   (2)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_n   (rst_n),
    .i_Switch_1(sw_1),
    .i_Switch_2(sw_2),
    .o_LED_1   (led)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic exp);
    checks++;
    if (led !== exp) begin
      errors++;
      $display("FAIL %s: led=%b expected=%b at t=%0t", name, led, exp, $time);
    end
  endtask

  // Inputs were changed just after edge 0; led must hold ~exp through edge n-1 and be exp at edge n.
  task automatic expect_edge(input string name, input logic exp, input int n);
    for (int e = 1; e <= n; e++) begin
      tick();
      chk($sformatf("%s edge %0d", name, e), (e == n) ? exp : ~exp);
    end
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    vecs[0] = '{s1: 1'b0, s2: 1'b0, hold: 20, exp: 1'b0};
    vecs[1] = '{s1: 1'b0, s2: 1'b1, hold: 20, exp: 1'b0};
    vecs[2] = '{s1: 1'b1, s2: 1'b0, hold: 20, exp: 1'b0};
    vecs[3] = '{s1: 1'b1, s2: 1'b1, hold: 20, exp: 1'b1};
    vecs[4] = '{s1: 1'b0, s2: 1'b1, hold: 20, exp: 1'b0};
    vecs[5] = '{s1: 1'b1, s2: 1'b1, hold: 20, exp: 1'b1};

    // Reset held with both switches pressed
    rst_n = 1'b0;
    sw_1  = 1'b1;
    sw_2  = 1'b1;
    #1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("reset hold edge %0d", e), 1'b0);
    end
    rst_n = 1'b1;
    expect_edge("post-reset rise", 1'b1, LAT);

    // Steady-state truth table
    for (int v = 0; v < 6; v++) begin
      sw_1 = vecs[v].s1;
      sw_2 = vecs[v].s2;
      hold(vecs[v].hold);
      chk($sformatf("truth vec %0d (%b%b)", v, vecs[v].s1, vecs[v].s2), vecs[v].exp);
    end

    // Exact latency, rising then falling
    sw_1 = 1'b1;
    sw_2 = 1'b0;
    hold(20);
    chk("latency setup 10", 1'b0);
    sw_2 = 1'b1;
    expect_edge("latency rise", 1'b1, LAT);
    sw_1 = 1'b0;
    expect_edge("latency fall", 1'b0, LAT);

    sw_1 = 1'b1;
    sw_2 = 1'b1;
    hold(20);
    chk("glitch setup 11", 1'b1);

`ifdef AND_GATE_PROJECT_DEBOUNCE_EN
    // 3-cycle low pulse is rejected
    sw_2 = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      if (e == 4) sw_2 = 1'b1;
      tick();
      chk($sformatf("pulse3 edge %0d", e), 1'b1);
      if (e == 3) sw_2 = 1'b1;
    end

    // 4-cycle low pulse passes: led low at edges 7..10, back at 11
    sw_2 = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 4) sw_2 = 1'b1;
      chk($sformatf("pulse4 edge %0d", e), !(e >= 7 && e <= 10));
    end
`else
    // 1-cycle low pulse on switch 1 shows as a 1-cycle led dip at edge 3
    sw_1 = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 1) sw_1 = 1'b1;
      chk($sformatf("pulse1 edge %0d", e), e != 3);
    end
`endif

    // Reset partway through a qualifying 0->1 transition
    sw_1 = 1'b0;
    sw_2 = 1'b1;
    hold(20);
    chk("midreset setup 01", 1'b0);
    sw_1 = 1'b1;
    hold(PRE_RST);
    chk("midreset before reset", 1'b0);
    rst_n = 1'b0;
    tick();
    chk("midreset in reset", 1'b0);
    rst_n = 1'b1;
    expect_edge("midreset full latency", 1'b1, LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
